// File: rtl/core_mem_arb.sv
// Single-port RAM arbiter between fetch (I) and load/store (D) ports, one transaction at a time.
// Define CORE_MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module core_mem_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            I_REQ,
    input  logic [AW-1:0]   I_ADDR,
    output logic [DW-1:0]   I_RDATA,
    output logic            I_ACK,
    input  logic            D_REQ,
    input  logic            D_WE,
    input  logic [DW/8-1:0] D_BE,
    input  logic [AW-1:0]   D_ADDR,
    input  logic [DW-1:0]   D_WDATA,
    output logic [DW-1:0]   D_RDATA,
    output logic            D_ACK,
    output logic            M_EN,
    output logic            M_WE,
    output logic [DW/8-1:0] M_BE,
    output logic [AW-1:0]   M_ADDR,
    output logic [DW-1:0]   M_WDATA,
    input  logic [DW-1:0]   M_RDATA
);
    localparam int BW = DW / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        ISSUE = 3'b010,
        RESP  = 3'b100
    } state_e;

    state_e          state_q;
    logic            owner_d_q;
    logic            wr_q;
    logic [DW-1:0]   i_rdata_q;
    logic [DW-1:0]   d_rdata_q;
    logic            i_ack_q;
    logic            d_ack_q;
    logic            m_en_q;
    logic            m_we_q;
    logic [BW-1:0]   m_be_q;
    logic [AW-1:0]   m_addr_q;
    logic [DW-1:0]   m_wdata_q;
`ifdef CORE_MEM_ARB_RR_EN
    logic            last_d_q;
`endif

    logic            i_elig;
    logic            d_elig;
    logic            grant_d_d;

    // A port whose ACK is high this cycle is still holding REQ; mask it to avoid a double grant.
    always_comb begin
        i_elig    = I_REQ & ~i_ack_q;
        d_elig    = D_REQ & ~d_ack_q;
        grant_d_d = d_elig;
`ifdef CORE_MEM_ARB_RR_EN
        if (d_elig && i_elig) begin
            grant_d_d = ~last_d_q;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            owner_d_q <= 1'b0;
            wr_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
`ifdef CORE_MEM_ARB_RR_EN
            last_d_q  <= 1'b0;
`endif
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_elig || d_elig) begin
                        owner_d_q <= grant_d_d;
                        wr_q      <= grant_d_d & D_WE;
                        m_en_q    <= 1'b1;
                        m_we_q    <= grant_d_d & D_WE;
                        if (grant_d_d) begin
                            m_addr_q  <= D_ADDR;
                            m_be_q    <= D_BE;
                            m_wdata_q <= D_WDATA;
                        end else begin
                            m_addr_q  <= I_ADDR;
                            m_be_q    <= '1;
                        end
`ifdef CORE_MEM_ARB_RR_EN
                        last_d_q  <= grant_d_d;
`endif
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_en_q  <= 1'b0;
                    m_we_q  <= 1'b0;
                    state_q <= RESP;
                end
                RESP: begin
                    // RAM data from the ISSUE cycle is valid now; writes leave D_RDATA alone.
                    if (owner_d_q) begin
                        if (!wr_q) begin
                            d_rdata_q <= M_RDATA;
                        end
                        d_ack_q <= 1'b1;
                    end else begin
                        i_rdata_q <= M_RDATA;
                        i_ack_q   <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign I_RDATA = i_rdata_q;
    assign I_ACK   = i_ack_q;
    assign D_RDATA = d_rdata_q;
    assign D_ACK   = d_ack_q;
    assign M_EN    = m_en_q;
    assign M_WE    = m_we_q;
    assign M_BE    = m_be_q;
    assign M_ADDR  = m_addr_q;
    assign M_WDATA = m_wdata_q;

endmodule

// File: doc/core_mem_arb.md
# core_mem_arb

Single-port memory arbiter for the multi-cycle core. It shares one synchronous RAM (1-cycle read latency) between the instruction-fetch port and the load/store port. Each port uses a REQ/ACK handshake. The arbiter runs one transaction at a time through a three-state sequencer and returns read data in a registered form to the winning port. It sits between the core's fetch/memory stages and the unified program/data RAM.

## Interface
Parameters:
- AW, 32, address width; word address, passed through unmodified.
- DW, 32, data width; byte enables are DW/8 wide.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, synchronous, active-low.
- I_REQ  in  1  fetch request; held with I_ADDR until I_ACK.
- I_ADDR  in  AW  fetch address.
- I_RDATA  out  DW  fetched word; valid when I_ACK=1, held afterwards.
- I_ACK  out  1  one-cycle completion pulse.
- D_REQ  in  1  data request; held with the D_* payload until D_ACK.
- D_WE  in  1  1=write, 0=read.
- D_BE  in  DW/8  byte enables for writes.
- D_ADDR  in  AW  data address.
- D_WDATA  in  DW  write data, already lane-replicated by the requester.
- D_RDATA  out  DW  read data; valid when D_ACK=1; unchanged on writes.
- D_ACK  out  1  one-cycle completion pulse.
- M_EN  out  1  RAM access strobe.
- M_WE  out  1  RAM write strobe.
- M_BE  out  DW/8  RAM byte enables.
- M_ADDR  out  AW  RAM address.
- M_WDATA  out  DW  RAM write data.
- M_RDATA  in  DW  RAM read data; valid the cycle after M_EN.

## Operation
- The state machine is one-hot with three states: IDLE, ISSUE, RESP.
- **IDLE:**
  - Sample eligible requests and pick a winner.
  - Latch the owner (I or D) and the payload into M_ADDR, M_WE, M_BE, M_WDATA.
  - Go to ISSUE.
  - With no eligible request, stay in IDLE.
- **ISSUE:**
  - Drive M_EN=1.
  - Drive M_WE=1 only for a D write; M_WE=0 for instruction requests and D reads.
  - Go to RESP.
- **RESP:**
  - For a read, capture M_RDATA into the owner's RDATA register.
  - For a D write, leave D_RDATA unchanged.
  - Set the owner's ACK register.
  - Go to IDLE.
- **Eligibility:** in the cycle a port's ACK=1, that port's REQ is masked. This prevents a double grant from a request that is still held.
- **Default arbitration:** fixed priority, D over I.
- **Outputs outside ISSUE:**
  - M_EN=0 and M_WE=0.
  - M_ADDR, M_BE and M_WDATA hold their last latched values.
- **D_WE=1 with D_BE=0:** the access is still issued with M_BE=0 and acked normally.
- **REQ dropped before ACK:** this is a protocol violation. The transaction still completes and ACK still pulses.
- The arbiter performs no alignment or range checks.

## Timing
- **Reset:**
  - Applied on any edge with RST_N=0.
  - State goes to IDLE.
  - All outputs go to 0: I_RDATA, D_RDATA, I_ACK, D_ACK, M_*.
  - The round-robin pointer resets to "I last granted".
- **Latency:** REQ sampled in IDLE at cycle k gives:
  - M_EN=1 in cycle k+1;
  - M_RDATA captured at the end of cycle k+2;
  - ACK=1 and RDATA valid in cycle k+3.
- **ACK cycle:** the state is IDLE again during the ACK cycle, so the other port can be granted in that same cycle.
- **Throughput:**
  - Alternating ports: one transaction every 3 cycles.
  - A single port re-requesting the cycle after its ACK: one transaction every 4 cycles.
- **Simultaneous I_REQ and D_REQ in IDLE:** exactly one is granted. The loser stays pending, with no ACK, until a later IDLE.
- **Reset mid-operation:**
  - The in-flight transaction is abandoned and no ACK is issued.
  - A write whose ISSUE cycle has already completed stays committed in the RAM.

## Configuration
- Macro: CORE_MEM_ARB_RR_EN.
- **Defined:**
  - Round-robin arbitration: on a conflict, grant the port not granted most recently.
  - The pointer updates on every grant.
  - The first conflict after reset goes to D.
- **Undefined:**
  - Fixed D-over-I priority.
  - There is no pointer register, and the I port can starve while D_REQ is continuously eligible.

## Test plan
- **Single fetch:**
  - Stimulus: RAM[0x10]=0x00500093; I_REQ=1, I_ADDR=0x10 at cycle 0.
  - Required: M_EN=1, M_ADDR=0x10, M_WE=0 in cycle 1; I_ACK=1 and I_RDATA=0x00500093 in cycle 3 only.
- **Byte-lane write:**
  - Stimulus: RAM[0x20]=0x11223344; D write with D_BE=0011, D_WDATA=0xDEADBEEF.
  - Required: M_WE=1 and M_BE=0011 for exactly one cycle; D_RDATA unchanged; a following D read of 0x20 returns 0x1122BEEF.
- **Conflict, macro undefined:**
  - Stimulus: I_REQ and D_REQ both asserted at cycle 0, each dropped after its ACK.
  - Required: D_ACK at cycle 3, I_ACK at cycle 6.
- **Conflict, CORE_MEM_ARB_RR_EN defined:**
  - Stimulus: both ports re-request immediately after each ACK for 12 cycles.
  - Required: grants alternate D, I, D, I with ACKs at cycles 3, 6, 9, 12.
- **Held request:**
  - Stimulus: I_REQ held high through and after I_ACK at cycle 3.
  - Required: no M_EN in cycle 4; the next grant comes from the IDLE sample at cycle 4, giving I_ACK at cycle 7.
- **Reset in RESP:**
  - Stimulus: RST_N=0 in cycle 2 of a D read.
  - Required: no D_ACK; all outputs 0; a fresh I_REQ after release is served with 3-cycle latency.
